// File: rtl/qsys_cpu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : qsys_cpu_mul_seq
// Description : Nios II mul/mulxuu/mulxss/mulxsu sequencer time-sharing one
//               registered 16x16 multiplier cell. Optional zero-operand
//               bypass is enabled with QSYS_CPU_MUL_SEQ_ZERO_SKIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module qsys_cpu_mul_seq #(
    parameter int MC_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic [1:0]  req_op,
    output logic [15:0] mc_a,
    output logic [15:0] mc_b,
    output logic        mc_en,
    input  logic [31:0] mc_p,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_DRAIN = 3'd2;
    localparam logic [2:0] c_ST_CORR  = 3'd3;
    localparam logic [2:0] c_ST_RESP  = 3'd4;

    localparam logic [1:0] c_OP_MUL    = 2'b00;
    localparam logic [1:0] c_OP_MULXSS = 2'b10;
    localparam logic [1:0] c_OP_MULXSU = 2'b11;

    logic [2:0]  r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_op;
    logic [1:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_rsp_data;

    // Product tags in flight: valid, last-of-request, weight code.
    logic [MC_LATENCY-1:0]      r_pv;
    logic [MC_LATENCY-1:0]      r_pl;
    logic [MC_LATENCY-1:0][1:0] r_pw;

    logic        w_accept;
    logic        w_is_mulx;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_issue;
    logic        w_last_issue;
    logic        w_capture;
    logic        w_last_capture;
    logic        w_zero_skip;
    logic [1:0]  w_weight;
    logic [63:0] w_term;
    logic [31:0] w_hi_corr;
    logic [63:0] w_acc_next;
    logic [2:0]  w_state_next;

    assign w_accept       = req_valid & req_ready;
    assign w_is_mulx      = (r_op != c_OP_MUL);
    assign w_a_signed     = (r_op == c_OP_MULXSS) | (r_op == c_OP_MULXSU);
    assign w_b_signed     = (r_op == c_OP_MULXSS);
    assign w_issue        = (r_state == c_ST_ISSUE);
    assign w_last_issue   = w_issue & (r_cnt == (w_is_mulx ? 2'd3 : 2'd2));
    assign w_capture      = r_pv[MC_LATENCY-1];
    assign w_last_capture = w_capture & r_pl[MC_LATENCY-1];

`ifdef QSYS_CPU_MUL_SEQ_ZERO_SKIP_EN
    assign w_zero_skip = (req_src1 == 32'd0) | (req_src2 == 32'd0);
`else
    assign w_zero_skip = 1'b0;
`endif

    // Issue order LL, LH, HL, HH; weight code 0 -> 2^0, 1 -> 2^16, 2 -> 2^32.
    always_comb begin
        w_weight = 2'd1;
        if (r_cnt == 2'd0) begin
            w_weight = 2'd0;
        end else if (r_cnt == 2'd3) begin
            w_weight = 2'd2;
        end
    end

    always_comb begin
        mc_a = 16'd0;
        mc_b = 16'd0;
        if (w_issue) begin
            mc_a = r_cnt[1] ? r_a[31:16] : r_a[15:0];
            mc_b = r_cnt[0] ? r_b[31:16] : r_b[15:0];
        end
    end

    always_comb begin
        w_term = 64'd0;
        case (r_pw[MC_LATENCY-1])
            2'd0:    w_term = {32'd0, mc_p};
            2'd1:    w_term = {16'd0, mc_p, 16'd0};
            default: w_term = {mc_p, 32'd0};
        endcase
    end

    // Signed high-word fix-up applied to the unsigned 64-bit product.
    assign w_hi_corr = r_acc[63:32]
                     - ((w_a_signed & r_a[31]) ? r_b : 32'd0)
                     - ((w_b_signed & r_b[31]) ? r_a : 32'd0);

    always_comb begin
        w_acc_next = r_acc;
        if (r_state == c_ST_CORR) begin
            w_acc_next = {w_hi_corr, r_acc[31:0]};
        end else if (w_capture) begin
            w_acc_next = r_acc + w_term;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept) w_state_next = w_zero_skip ? c_ST_RESP : c_ST_ISSUE;
            c_ST_ISSUE: if (w_last_issue) w_state_next = c_ST_DRAIN;
            c_ST_DRAIN: if (w_last_capture) w_state_next = w_is_mulx ? c_ST_CORR : c_ST_RESP;
            c_ST_CORR:  w_state_next = c_ST_RESP;
            c_ST_RESP:  if (rsp_ready) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_op       <= 2'd0;
            r_cnt      <= 2'd0;
            r_acc      <= 64'd0;
            r_rsp_data <= 32'd0;
            r_pv       <= '0;
            r_pl       <= '0;
            r_pw       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a   <= req_src1;
                r_b   <= req_src2;
                r_op  <= req_op;
                r_cnt <= 2'd0;
                r_acc <= 64'd0;
            end else begin
                r_acc <= w_acc_next;
                if (w_issue) begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end
            r_pv[0] <= w_issue;
            r_pl[0] <= w_last_issue;
            r_pw[0] <= w_weight;
            for (int i = 1; i < MC_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pl[i] <= r_pl[i-1];
                r_pw[i] <= r_pw[i-1];
            end
            // Result word is frozen on RESP entry so it holds through back-pressure.
            if ((r_state != c_ST_RESP) && (w_state_next == c_ST_RESP)) begin
                if (r_state == c_ST_IDLE) begin
                    r_rsp_data <= 32'd0;
                end else begin
                    r_rsp_data <= w_is_mulx ? w_acc_next[63:32] : w_acc_next[31:0];
                end
            end
        end
    end

    assign req_ready = (r_state == c_ST_IDLE);
    assign busy      = (r_state != c_ST_IDLE);
    assign rsp_valid = (r_state == c_ST_RESP);
    assign rsp_data  = r_rsp_data;
    assign mc_en     = (r_state == c_ST_ISSUE) | (r_state == c_ST_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_qsys_cpu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_qsys_cpu_mul_seq
// Description : Directed bench for qsys_cpu_mul_seq at MC_LATENCY 1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qsys_cpu_mul_seq;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
`ifdef QSYS_CPU_MUL_SEQ_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       req_valid, req_ready, mc_en, rsp_valid, rsp_ready, busy;
    logic [1:0][31:0] src1, src2, mc_p, rsp_data;
    logic [1:0][1:0]  req_op;
    logic [1:0][15:0] mc_a, mc_b;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int lat_c [2] = '{LAT0, LAT1};

    qsys_cpu_mul_seq #(.MC_LATENCY(LAT0)) u_dut0 (
        .clk(clk), .reset(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_src1(src1[0]), .req_src2(src2[0]), .req_op(req_op[0]),
        .mc_a(mc_a[0]), .mc_b(mc_b[0]), .mc_en(mc_en[0]), .mc_p(mc_p[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .busy(busy[0])
    );

    qsys_cpu_mul_seq #(.MC_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .reset(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_src1(src1[1]), .req_src2(src2[1]), .req_op(req_op[1]),
        .mc_a(mc_a[1]), .mc_b(mc_b[1]), .mc_en(mc_en[1]), .mc_p(mc_p[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .busy(busy[1])
    );

    // Multiplier cells: enable-gated pipelines of depth 1 and 3.
    logic [31:0] pipe0;
    logic [31:0] pipe1 [3];
    always @(posedge clk) if (mc_en[0]) pipe0 <= {16'd0, mc_a[0]} * {16'd0, mc_b[0]};
    always @(posedge clk) if (mc_en[1]) begin
        pipe1[0] <= {16'd0, mc_a[1]} * {16'd0, mc_b[1]};
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign mc_p[0] = pipe0;
    assign mc_p[1] = pipe1[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d got=%0h expected=%0h at cycle %0d", nm, k, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = (op[1] && a[31]) ? {32'hFFFF_FFFF, a} : {32'd0, a};
        xb = (op == 2'b10 && b[31]) ? {32'hFFFF_FFFF, b} : {32'd0, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Reference model state per DUT
    logic        act [2] = '{1'b0, 1'b0};
    int          t0 [2], elat [2], niss [2];
    logic [31:0] ea [2], eb [2], edata [2];
    int          mc_cnt [2], iss_cnt [2];
    int          md;
    logic [15:0] ex_a, ex_b;
    logic        zero;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mc_en[k]) mc_cnt[k]++;
            if (mc_en[k] && (mc_a[k] != 16'd0 || mc_b[k] != 16'd0)) iss_cnt[k]++;
            if (rst || !act[k]) begin
                chk("idle_req_ready", k, req_ready[k], 1);
                chk("idle_busy", k, busy[k], 0);
                chk("idle_rsp_valid", k, rsp_valid[k], 0);
                chk("idle_mc_en", k, mc_en[k], 0);
                chk("idle_mc_ab", k, {mc_a[k], mc_b[k]}, 0);
                if (!rst && req_valid[k] && req_ready[k]) begin
                    act[k]   = 1'b1;
                    t0[k]    = cyc;
                    ea[k]    = src1[k];
                    eb[k]    = src2[k];
                    edata[k] = model(req_op[k], src1[k], src2[k]);
                    zero     = ZS && (src1[k] == 0 || src2[k] == 0);
                    if (zero) edata[k] = 32'd0;
                    elat[k]  = zero ? 1 : ((req_op[k] == 2'b00) ? 4 : 6) + lat_c[k];
                    niss[k]  = zero ? 0 : ((req_op[k] == 2'b00) ? 3 : 4);
                end
            end else begin
                md = cyc - t0[k];
                chk("busy_req_ready", k, req_ready[k], 0);
                chk("busy_busy", k, busy[k], 1);
                chk("mc_en", k, mc_en[k], (niss[k] > 0 && md >= 1 && md <= niss[k] + lat_c[k]) ? 1 : 0);
                ex_a = 16'd0;
                ex_b = 16'd0;
                if (md >= 1 && md <= niss[k]) begin
                    ex_a = (md >= 3) ? ea[k][31:16] : ea[k][15:0];
                    ex_b = (md == 2 || md == 4) ? eb[k][31:16] : eb[k][15:0];
                end
                chk("mc_ab", k, {mc_a[k], mc_b[k]}, {ex_a, ex_b});
                if (md >= elat[k]) begin
                    chk("rsp_valid", k, rsp_valid[k], 1);
                    chk("rsp_data", k, rsp_data[k], edata[k]);
                    if (rsp_ready[k]) act[k] = 1'b0;
                end else begin
                    chk("rsp_valid_early", k, rsp_valid[k], 0);
                end
            end
        end
    end

    task automatic run(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, input int lit_lat, input string nm);
        int t_hs;
        int n;
        mc_cnt[k]  = 0;
        iss_cnt[k] = 0;
        @(posedge clk); #1;
        req_valid[k] = 1'b1;
        req_op[k]    = op;
        src1[k]      = a;
        src2[k]      = b;
        n = 0;
        while (!req_ready[k] && n < 50) begin @(posedge clk); #1; n++; end
        chk({nm, "_accept"}, k, req_ready[k], 1);
        t_hs = cyc;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        n = 0;
        while (!rsp_valid[k] && n < 50) begin @(posedge clk); #1; n++; end
        chk({nm, "_data"}, k, rsp_data[k], lit);
        chk({nm, "_latency"}, k, cyc - t_hs, lit_lat);
        @(posedge clk); #1;
    endtask

    initial begin
        int h;
        int t2;
        int n;
        req_valid = '0;
        rsp_ready = '1;
        req_op    = '0;
        src1      = '0;
        src2      = '0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", k, req_ready[k], 1);
            chk("rst_rsp_valid", k, rsp_valid[k], 0);
            chk("rst_rsp_data", k, rsp_data[k], 0);
            chk("rst_mc", k, {mc_en[k], mc_a[k], mc_b[k]}, 0);
            chk("rst_busy", k, busy[k], 0);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5, "mul_ff");
        chk("mul_ff_mc_en_cycles", 0, mc_cnt[0], 4);
        chk("mul_ff_issue_cycles", 0, iss_cnt[0], 3);
        run(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7, "mulxuu_ff");
        chk("mulxuu_ff_issue_cycles", 0, iss_cnt[0], 4);
        run(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 7, "mulxss_ff");
        run(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, "mulxsu_ff");
        run(0, 2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 7, "mulxss_min");
        run(0, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 7, "mulxsu_min");
        run(0, 2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 7, "mulxss_neg");
        run(0, 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 5, "mul_neg");
        run(0, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, model(2'b00, 32'h1234_5678, 32'h9ABC_DEF0), 5, "mul_mix");
        run(0, 2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, model(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D), 7, "mulxsu_mix");

        run(1, 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 9, "l3_mulxuu");
        run(1, 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 7, "l3_mul");
        run(1, 2'b10, 32'h8765_4321, 32'h0FED_CBA9, model(2'b10, 32'h8765_4321, 32'h0FED_CBA9), 9, "l3_mulxss");

        // Back-pressure with a second request pending the whole time
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_op[0]    = 2'b00;
        src1[0]      = 32'd7;
        src2[0]      = 32'd6;
        h = cyc;
        @(posedge clk); #1;
        req_op[0] = 2'b01;
        src1[0]   = 32'h0001_0000;
        src2[0]   = 32'h0001_0000;
        n = 0;
        while (!rsp_valid[0] && n < 50) begin @(posedge clk); #1; n++; end
        chk("stall_latency", 0, cyc - h, 5);
        for (int s = 0; s < 5; s++) begin
            chk("stall_rsp_valid", 0, rsp_valid[0], 1);
            chk("stall_rsp_data", 0, rsp_data[0], 32'h0000_002A);
            chk("stall_req_ready", 0, req_ready[0], 0);
            @(posedge clk); #1;
        end
        chk("stall_rsp_valid_end", 0, rsp_valid[0], 1);
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("b2b_ready_after_hs", 0, req_ready[0], 1);
        t2 = cyc;
        @(posedge clk); #1;
        chk("b2b_taken", 0, req_ready[0], 0);
        req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 50) begin @(posedge clk); #1; n++; end
        chk("b2b_data", 0, rsp_data[0], 32'h0000_0001);
        chk("b2b_latency", 0, cyc - t2, 7);
        @(posedge clk); #1;

        // Reset in the middle of a MULXSS
        req_valid[0] = 1'b1;
        req_op[0]    = 2'b10;
        src1[0]      = 32'hFFFF_FFFF;
        src2[0]      = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        act[0] = 1'b0;
        act[1] = 1'b0;
        #1;
        chk("arst_req_ready", 0, req_ready[0], 1);
        chk("arst_busy", 0, busy[0], 0);
        chk("arst_rsp_valid", 0, rsp_valid[0], 0);
        chk("arst_rsp_data", 0, rsp_data[0], 0);
        chk("arst_mc", 0, {mc_en[0], mc_a[0], mc_b[0]}, 0);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        run(0, 2'b00, 32'd3, 32'd5, 32'h0000_000F, 5, "post_rst_mul");

        run(0, 2'b10, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, ZS ? 1 : 7, "zero_mulxss");
        chk("zero_mc_en_cycles", 0, mc_cnt[0], ZS ? 0 : 5);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
